// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
//
// Inhibits the bus by holding kclk low, issues a request-to-send, then
// shifts out start/8 data (LSB first)/odd parity/stop on keyboard-generated
// kclk falling edges, and checks the device acknowledge on the 11th edge.
//
// Ports:
//   clk       system clock (single clock domain)
//   reset     asynchronous active-low reset
//   tx_data   command byte, latched when tx_valid && tx_ready
//   tx_valid  send request
//   tx_ready  idle and able to accept a send
//   kclk      raw PS/2 clock line level (asynchronous)
//   kdata     raw PS/2 data line level (asynchronous)
//   kclk_oe   1 pulls the open-drain kclk line low
//   kdata_oe  1 pulls the open-drain kdata line low
//   done      one-cycle pulse: byte sent and acknowledged
//   err       one-cycle pulse: no acknowledge (or watchdog expiry)
//
// Build option: define PS2_TX_TIMEOUT_EN to add a watchdog that aborts a
// transfer when no kclk falling edge arrives within TIMEOUT_CYCLES clocks.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       kclk,
    input  logic       kdata,
    output logic       kclk_oe,
    output logic       kdata_oe,
    output logic       done,
    output logic       err
);

    localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned FltW = $clog2(FILTER_LEN + 1);
    localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
    localparam logic [FltW-1:0] FltLast = FltW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StSend,
        StAck,
        StLineIdle
    } state_e;

    // Synchronizers, reset to the idle (high) line level.
    logic [1:0] kclk_sync_q;
    logic [1:0] kdata_sync_q;
    logic       kclk_s;
    logic       kdata_s;

    assign kclk_s  = kclk_sync_q[1];
    assign kdata_s = kdata_sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kclk_sync_q  <= 2'b11;
            kdata_sync_q <= 2'b11;
        end else begin
            kclk_sync_q  <= {kclk_sync_q[0], kclk};
            kdata_sync_q <= {kdata_sync_q[0], kdata};
        end
    end

    // Glitch filter: a new level is taken after FILTER_LEN consecutive samples
    // that differ from the current filtered level.
    logic            kclk_flt_q;
    logic [FltW-1:0] flt_cnt_q;
    logic            flt_accept;
    logic            kclk_fall;

    assign flt_accept = (kclk_s != kclk_flt_q) && (flt_cnt_q == FltLast);
    assign kclk_fall  = flt_accept && kclk_flt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kclk_flt_q <= 1'b1;
            flt_cnt_q  <= '0;
        end else if (kclk_s == kclk_flt_q) begin
            flt_cnt_q <= '0;
        end else if (flt_accept) begin
            kclk_flt_q <= kclk_s;
            flt_cnt_q  <= '0;
        end else begin
            flt_cnt_q <= flt_cnt_q + 1'b1;
        end
    end

    state_e          state_q;
    logic [InhW-1:0] inh_cnt_q;
    logic [3:0]      bit_cnt_q;
    logic [7:0]      data_q;
    logic            parity_q;
    logic            wd_expired;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

    logic [WdW-1:0] wd_q;
    logic           wd_run;

    assign wd_run     = (state_q == StReq) || (state_q == StSend) ||
                        (state_q == StAck) || (state_q == StLineIdle);
    assign wd_expired = wd_run && !kclk_fall && (wd_q == WdLast);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
        end else if (!wd_run || kclk_fall) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            inh_cnt_q <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            parity_q  <= 1'b0;
            tx_ready  <= 1'b1;
            kclk_oe   <= 1'b0;
            kdata_oe  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (wd_expired) begin
                state_q  <= StIdle;
                kclk_oe  <= 1'b0;
                kdata_oe <= 1'b0;
                err      <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        // tx_ready is held low through the done/err cycle so the
                        // next send is taken no earlier than the cycle after it.
                        if (!tx_ready) begin
                            tx_ready <= 1'b1;
                        end else if (tx_valid) begin
                            data_q    <= tx_data;
                            parity_q  <= ~^tx_data;
                            tx_ready  <= 1'b0;
                            kclk_oe   <= 1'b1;
                            inh_cnt_q <= '0;
                            state_q   <= StInhibit;
                        end
                    end
                    StInhibit: begin
                        if (inh_cnt_q == InhLast) begin
                            kdata_oe <= 1'b1;
                            state_q  <= StReq;
                        end else begin
                            inh_cnt_q <= inh_cnt_q + 1'b1;
                        end
                    end
                    StReq: begin
                        // Start bit stays driven on kdata; kclk handed to device.
                        kclk_oe   <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= StSend;
                    end
                    StSend: begin
                        if (kclk_fall) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q < 4'd8) begin
                                kdata_oe <= ~data_q[bit_cnt_q[2:0]];
                            end else if (bit_cnt_q == 4'd8) begin
                                kdata_oe <= ~parity_q;
                            end else begin
                                kdata_oe <= 1'b0;
                                state_q  <= StAck;
                            end
                        end
                    end
                    StAck: begin
                        if (kclk_fall) begin
                            if (!kdata_s) begin
                                state_q <= StLineIdle;
                            end else begin
                                err     <= 1'b1;
                                state_q <= StIdle;
                            end
                        end
                    end
                    StLineIdle: begin
                        if (kclk_flt_q && kdata_s) begin
                            done    <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a keyboard model clocks bytes out of the DUT while
// a compare process checks every cycle against a behavioural model of the
// expected line drive (driven bit = f(number of falling edges recognised)).
module tb_ps2_host_tx;

    localparam int unsigned Inh  = 300;
    localparam int unsigned Tmo  = 3000;
    localparam int unsigned Flt  = 8;
    localparam int unsigned Half = 20;
    // Raw kclk edge to DUT reaction: 2 sync stages + FILTER_LEN samples.
    localparam int Lat = Flt + 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       kclk_oe, kdata_oe, done, err;
    logic       kbd_clk_low = 1'b0;
    logic       kbd_dat_low = 1'b0;
    logic       kclk_line, kdata_line;

    assign kclk_line  = ~(kclk_oe | kbd_clk_low);
    assign kdata_line = ~(kdata_oe | kbd_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(Inh),
        .TIMEOUT_CYCLES(Tmo),
        .FILTER_LEN    (Flt)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .kclk    (kclk_line),
        .kdata   (kdata_line),
        .kclk_oe (kclk_oe),
        .kdata_oe(kdata_oe),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state.
    bit         m_busy = 1'b0;
    bit         m_send = 1'b0;
    bit         noise = 1'b0;
    logic [7:0] m_byte = 8'h00;
    int         m_nfall = 0;
    int         m_rc[1:11];
    int         n_done = 0;
    int         n_err = 0;
    int         err_cyc = 0;
    int         cmp_n;
    logic [7:0] last_rx;
    logic       last_par;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2 == 0);
    endfunction

    // Line drive expected after n recognised falling edges.
    function automatic logic exp_oe(input int n, input logic [7:0] b);
        if (n == 0) return 1'b1;
        if (n <= 8) return ~b[n-1];
        if (n == 9) return ~odd_par(b);
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        #2;
        check("done_err_exclusive", {31'd0, done & err}, 0);
        if (m_busy) begin
            check("tx_ready_busy", {31'd0, tx_ready}, 0);
        end else begin
            check("tx_ready_idle", {31'd0, tx_ready}, 1);
            check("kclk_oe_idle", {31'd0, kclk_oe}, 0);
            check("kdata_oe_idle", {31'd0, kdata_oe}, 0);
        end
        if (m_send && !err) begin
            cmp_n = 0;
            for (int i = 1; i <= m_nfall; i++) if (m_rc[i] <= cyc) cmp_n++;
            check("kdata_oe_bit", {31'd0, kdata_oe}, {31'd0, exp_oe(cmp_n, m_byte)});
            check("kclk_oe_send", {31'd0, kclk_oe}, 0);
        end
        if (done) n_done++;
        if (err) begin
            n_err++;
            err_cyc = cyc;
        end
    end

    task automatic step();
        @(negedge clk);
        if (m_busy && (done || err)) begin
            m_busy   = 1'b0;
            m_send   = 1'b0;
            noise    = 1'b0;
            tx_valid = 1'b0;
        end else if (noise) begin
            tx_valid = 1'($urandom);
            tx_data  = 8'($urandom);
        end
    endtask

    task automatic do_reset();
        #1;
        reset       = 1'b0;
        m_busy      = 1'b0;
        m_send      = 1'b0;
        noise       = 1'b0;
        tx_valid    = 1'b0;
        kbd_clk_low = 1'b0;
        kbd_dat_low = 1'b0;
        #1;
        check("reset_kclk_oe", {31'd0, kclk_oe}, 0);
        check("reset_kdata_oe", {31'd0, kdata_oe}, 0);
        check("reset_tx_ready", {31'd0, tx_ready}, 1);
        check("reset_done_err", {30'd0, done, err}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step();
    endtask

    // mode 0: run to done/err; 1: reset after last edge; 2: watchdog scenario.
    task automatic send(input logic [7:0] d, input bit ack, input int stop_after,
                        input bit glitch, input int mode);
        int         k;
        int         d0, e0;
        logic [7:0] rx;
        logic       rpar, rstop;
        rx = 8'h00; rpar = 1'b0; rstop = 1'b0;
        k = 0;
        while (!tx_ready && k < 100) begin step(); k++; end
        check("ready_before_send", {31'd0, tx_ready}, 1);
        @(negedge clk);
        tx_data = d; tx_valid = 1'b1;
        m_byte = d; m_nfall = 0; m_busy = 1'b1;
        d0 = n_done; e0 = n_err;
        @(negedge clk);
        tx_valid = 1'b0; noise = 1'b1;
        k = 0;
        while (kclk_oe && !kdata_oe && k < int'(Inh) + 20) begin step(); k++; end
        check("inhibit_len", k, Inh);
        check("req_phase", {30'd0, kclk_oe, kdata_oe}, 2'b11);
        step();
        check("start_bit", {30'd0, kclk_oe, kdata_oe}, 2'b01);
        m_send = 1'b1;
        repeat (Half) step();
        for (int e = 1; e <= 11 && e <= stop_after; e++) begin
            kbd_clk_low = 1'b1;
            m_nfall++;
            m_rc[m_nfall] = cyc + Lat;
            repeat (Half) step();
            if (e <= 8) rx[e-1] = ~kdata_oe;
            else if (e == 9) rpar = ~kdata_oe;
            else if (e == 10) rstop = ~kdata_oe;
            kbd_clk_low = 1'b0;
            if (e == 10 && ack) kbd_dat_low = 1'b1;
            if (e == 11) kbd_dat_low = 1'b0;
            repeat (Half) step();
            if (glitch && e == 4) begin
                kbd_clk_low = 1'b1; step(); kbd_clk_low = 1'b0;
                repeat (Half) step();
                kbd_clk_low = 1'b1; repeat (5) step(); kbd_clk_low = 1'b0;
                repeat (Half) step();
            end
        end
        last_rx = rx; last_par = rpar;
        if (stop_after >= 10) begin
            check("rx_byte", rx, d);
            check("rx_parity", {31'd0, rpar}, {31'd0, odd_par(d)});
            check("rx_stop", {31'd0, rstop}, 1);
        end
        if (mode == 0) begin
            k = 0;
            while (n_done + n_err == d0 + e0 && k < 1000) begin step(); k++; end
            repeat (3) step();
            check("done_count", n_done - d0, {31'd0, ack});
            check("err_count", n_err - e0, {31'd0, !ack});
        end else if (mode == 1) begin
            do_reset();
        end else begin
`ifdef PS2_TX_TIMEOUT_EN
            k = 0;
            while (n_err == e0 && k < int'(Tmo) + 200) begin step(); k++; end
            repeat (3) step();
            check("wd_err_count", n_err - e0, 1);
            check("wd_done_count", n_done - d0, 0);
            check("wd_err_time", err_cyc - m_rc[3], Tmo);
`else
            repeat (Tmo + 200) step();
            check("stay_busy", {31'd0, tx_ready}, 0);
            check("no_err", n_err - e0, 0);
            check("no_done", n_done - d0, 0);
            do_reset();
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got cycle %0d expected end", cyc);
        $fatal(1);
    end

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_ready", {31'd0, tx_ready}, 1);
        check("rst_oe", {30'd0, kclk_oe, kdata_oe}, 0);
        check("rst_done_err", {30'd0, done, err}, 0);
        reset = 1'b1;
        repeat (5) step();

        send(8'hED, 1'b1, 11, 1'b0, 0);
        check("ed_bits", last_rx, 8'hED);
        check("ed_parity", {31'd0, last_par}, 1);
        send(8'h01, 1'b1, 11, 1'b0, 0);
        check("x01_parity", {31'd0, last_par}, 0);
        send(8'hFF, 1'b1, 11, 1'b0, 0);
        check("xff_parity", {31'd0, last_par}, 1);
        send(8'h6B, 1'b0, 11, 1'b0, 0);
        send(8'h5A, 1'b1, 11, 1'b1, 0);
        check("glitch_bits", last_rx, 8'h5A);
        send(8'h3C, 1'b1, 4, 1'b0, 1);
        send(8'hF4, 1'b1, 11, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            send(8'($urandom), $urandom_range(0, 3) != 0, 11, 1'($urandom_range(0, 1)), 0);
        end
        send(8'h97, 1'b1, 3, 1'b0, 2);
        send(8'hA5, 1'b1, 11, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
